// File: rtl/stall_control_if.sv
// Hazard-unit bus: ID/EX/MEM hazard inputs and the
// pipeline enable/bubble/flush controls with event counters.
interface stall_control_if;
    logic [4:0]  regRSID;
    logic [4:0]  regRTID;
    logic        useRTID;
    logic        memreadex;
    logic [4:0]  writeRegEX;
    logic        memreadmem;
    logic [4:0]  writeRegMEM;
    logic        branchEX;
    logic        pcWrite;
    logic        ifidWrite;
    logic        idexBubble;
    logic        ifidFlush;
    logic        idexFlush;
    logic [15:0] stallCycles;
    logic [15:0] flushCount;

    modport master (
        output regRSID, regRTID, useRTID,
        output memreadex, writeRegEX,
        output memreadmem, writeRegMEM,
        output branchEX,
        input  pcWrite, ifidWrite, idexBubble,
        input  ifidFlush, idexFlush,
        input  stallCycles, flushCount
    );

    modport slave (
        input  regRSID, regRTID, useRTID,
        input  memreadex, writeRegEX,
        input  memreadmem, writeRegMEM,
        input  branchEX,
        output pcWrite, ifidWrite, idexBubble,
        output ifidFlush, idexFlush,
        output stallCycles, flushCount
    );
endinterface

// File: rtl/stall_control.sv
// Load-use stall and branch-flush controller with
// saturating stall/flush event counters.
module stall_control (
    input  logic            clk,
    input  logic            rst_n,
    stall_control_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic        haz_ex, haz_mem;
    logic        stall, flush;

    function automatic logic match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rt
    );
        return (r != 5'd0) && ((r == rs) || (use_rt && (r == rt)));
    endfunction

    assign haz_ex  = bus.memreadex &&
                     match(bus.writeRegEX, bus.regRSID, bus.regRTID, bus.useRTID);
    assign haz_mem = bus.memreadmem &&
                     match(bus.writeRegMEM, bus.regRSID, bus.regRTID, bus.useRTID);

    // Flush always beats stall: the dependent ID instruction is discarded.
    always_comb begin
        state_d = RUN;
        stall   = 1'b0;
        flush   = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (bus.branchEX) begin
                        flush = 1'b1;
                    end else if (haz_ex) begin
                        stall   = 1'b1;
                        state_d = HOLD;
                    end else if (haz_mem) begin
                        stall = 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.branchEX) flush = 1'b1;
                    else              stall = 1'b1;
                end
            endcase
        end
    end

    assign stall_d = (stall && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    assign flush_d = (flush && flush_q != 16'hFFFF) ? flush_q + 16'd1 : flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.pcWrite     = ~stall;
    assign bus.ifidWrite   = ~stall;
    assign bus.idexBubble  = stall;
    assign bus.ifidFlush   = flush;
    assign bus.idexFlush   = flush;
    assign bus.stallCycles = stall_q;
    assign bus.flushCount  = flush_q;
endmodule

// File: tb/tb_stall_control.sv
// Scoreboard bench for stall_control: directed vectors push
// expected controls/counters; a negedge monitor pops and compares.
module tb_stall_control;
    logic clk;
    logic rst_n;

    stall_control_if bus ();

    stall_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [4:0]  ctl;
        logic [15:0] st;
        logic [15:0] fl;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // ctl = {pcWrite, ifidWrite, idexBubble, ifidFlush, idexFlush}
    localparam logic [4:0] PASS  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00100;
    localparam logic [4:0] FLUSH = 5'b11011;

    task automatic vec(
        input string       nm,
        input logic        rst,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic        ur,
        input logic        mx,
        input logic [4:0]  wx,
        input logic        mm,
        input logic [4:0]  wm,
        input logic        br,
        input logic [4:0]  ctl,
        input logic [15:0] es,
        input logic [15:0] ef
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = rst;
        bus.regRSID     = rs;
        bus.regRTID     = rt;
        bus.useRTID     = ur;
        bus.memreadex   = mx;
        bus.writeRegEX  = wx;
        bus.memreadmem  = mm;
        bus.writeRegMEM = wm;
        bus.branchEX    = br;
        e.nm  = nm;
        e.ctl = ctl;
        e.st  = es;
        e.fl  = ef;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [4:0] got;
            e   = q.pop_front();
            got = {bus.pcWrite, bus.ifidWrite, bus.idexBubble,
                   bus.ifidFlush, bus.idexFlush};
            n_vec++;
            if (got !== e.ctl || bus.stallCycles !== e.st ||
                bus.flushCount !== e.fl) begin
                n_bad++;
                $display("FAIL %s: got ctl=%b stall=%h flush=%h, expected ctl=%b stall=%h flush=%h",
                         e.nm, got, bus.stallCycles, bus.flushCount,
                         e.ctl, e.st, e.fl);
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.regRSID     = '0;
        bus.regRTID     = '0;
        bus.useRTID     = 1'b0;
        bus.memreadex   = 1'b0;
        bus.writeRegEX  = '0;
        bus.memreadmem  = 1'b0;
        bus.writeRegMEM = '0;
        bus.branchEX    = 1'b0;
        repeat (2) @(posedge clk);

        //   name          rst rs  rt  ur mx wx  mm wm  br  ctl    stall flush
        vec("rst_force",   0, 8,  0,  0, 1, 8,  0, 0,  0, PASS,  0, 0);
        vec("ld1_c0",      1, 8,  0,  0, 1, 8,  0, 0,  0, STALL, 0, 0);
        vec("ld1_c1_hold", 1, 8,  0,  0, 0, 0,  1, 8,  0, STALL, 1, 0);
        vec("ld1_c2_pass", 1, 8,  0,  0, 0, 0,  0, 0,  0, PASS,  2, 0);
        vec("ld2_sw_rt",   1, 1,  9,  1, 0, 0,  1, 9,  0, STALL, 2, 0);
        vec("ld2_run",     1, 1,  9,  1, 0, 0,  0, 0,  0, PASS,  3, 0);
        vec("ld2_no_rt",   1, 1,  9,  0, 0, 0,  1, 9,  0, PASS,  3, 0);
        vec("br_haz",      1, 8,  0,  0, 1, 8,  0, 0,  1, FLUSH, 3, 0);
        vec("br_after",    1, 8,  0,  0, 0, 0,  0, 0,  0, PASS,  3, 1);
        vec("reg0",        1, 0,  0,  1, 1, 0,  1, 0,  0, PASS,  3, 1);
        vec("nonload",     1, 8,  8,  1, 0, 8,  0, 8,  0, PASS,  3, 1);
        vec("hold_enter",  1, 8,  0,  0, 1, 8,  0, 0,  0, STALL, 3, 1);
        vec("hold_rst",    0, 8,  0,  0, 0, 0,  1, 8,  0, PASS,  4, 1);
        vec("post_rst",    1, 8,  0,  0, 0, 0,  0, 0,  0, PASS,  0, 0);
        vec("hold2_enter", 1, 5,  0,  0, 1, 5,  0, 0,  0, STALL, 0, 0);
        vec("hold_br",     1, 5,  0,  0, 0, 0,  1, 5,  1, FLUSH, 1, 0);
        vec("hold_br_run", 1, 5,  0,  0, 0, 0,  0, 0,  0, PASS,  1, 1);

        for (int i = 0; i < 70000; i++) begin
            int c;
            c = (i + 1 > 65535) ? 65535 : i + 1;
            vec("sat_run",  1, 3,  0,  0, 0, 0,  1, 3,  0, STALL,
                16'(c), 1);
        end
        vec("sat_idle",    1, 3,  0,  0, 0, 0,  0, 0,  0, PASS,  16'hFFFF, 1);
        vec("sat_again",   1, 3,  0,  0, 0, 0,  1, 3,  0, STALL, 16'hFFFF, 1);
        vec("sat_nowrap",  1, 0,  0,  0, 0, 0,  0, 0,  0, PASS,  16'hFFFF, 1);

        repeat (3) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries unchecked, required 0",
                     q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
